// File: rtl/xprog_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encodings,
// length-field width and default geometry tied to the program RAM.
package xprog_loader_pkg;

   localparam int PROG_RAM_ADDR_W = 9;
   localparam int LDR_DATA_W_DEF  = 32;
   localparam int LDR_ADDR_W_DEF  = PROG_RAM_ADDR_W;
   localparam int LDR_LEN_W       = 16;

   typedef enum logic [2:0] {
      LDR_IDLE   = 3'd0,
      LDR_LEN_HI = 3'd1,
      LDR_LEN_LO = 3'd2,
      LDR_WORD   = 3'd3,
      LDR_WRITE  = 3'd4,
      LDR_CHK    = 3'd5,
      LDR_DONE   = 3'd6,
      LDR_ERR    = 3'd7
   } ldr_state_e;

endpackage

// File: rtl/xprog_ldr_asm.sv
// Byte-to-word shift assembler: bytes arrive MSB first, word_full flags the
// shift that completes a word so the loader can write it on the next cycle.
module xprog_ldr_asm
   import xprog_loader_pkg::*;
#(
   parameter int DATA_W = LDR_DATA_W_DEF
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [7:0]        byte_in,
   output logic [DATA_W-1:0] word,
   output logic              word_full
);

   localparam int BPW   = DATA_W / 8;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPW - 1);

   logic [DATA_W-1:0] word_q, word_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clear) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (shift_en) begin
         word_d = (word_q << 8) | DATA_W'(byte_in);
         cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign word      = word_q;
   assign word_full = shift_en && !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/xprog_loader.sv
// Boot-time program loader: length-prefixed byte stream into program RAM words.
// Optional trailing XOR checksum byte enabled by XPROG_LDR_CHECKSUM_EN.
module xprog_loader
   import xprog_loader_pkg::*;
#(
   parameter int DATA_W = LDR_DATA_W_DEF,
   parameter int ADDR_W = LDR_ADDR_W_DEF
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              data_sel,
   output logic              data_we,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_rst
);

   localparam logic [LDR_LEN_W:0] MAX_N = {{LDR_LEN_W{1'b0}}, 1'b1} << ADDR_W;

`ifdef XPROG_LDR_CHECKSUM_EN
   localparam ldr_state_e FINAL_ST = LDR_CHK;
`else
   localparam ldr_state_e FINAL_ST = LDR_DONE;
`endif

   ldr_state_e           state_q, state_d;
   logic [LDR_LEN_W-1:0] len_q, len_d;
   logic [LDR_LEN_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    din_q, din_d;
   logic [LDR_LEN_W:0]   n_rx;
   logic                 accept;
   logic                 asm_clear, asm_shift, asm_full;
   logic [DATA_W-1:0]    asm_word;
`ifdef XPROG_LDR_CHECKSUM_EN
   logic [7:0]           csum_q, csum_d;
`endif

   assign rx_ready = state_q inside {LDR_LEN_HI, LDR_LEN_LO, LDR_WORD, LDR_CHK};
   assign accept   = rx_valid && rx_ready;

   xprog_ldr_asm #(.DATA_W(DATA_W)) u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (asm_clear),
      .shift_en (asm_shift),
      .byte_in  (rx_data),
      .word     (asm_word),
      .word_full(asm_full)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      din_d     = din_q;
      n_rx      = '0;
      asm_clear = 1'b0;
      asm_shift = 1'b0;
`ifdef XPROG_LDR_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      case (state_q)
         LDR_IDLE, LDR_DONE, LDR_ERR: begin
            if (start) begin
               state_d   = LDR_LEN_HI;
               len_d     = '0;
               idx_d     = '0;
               addr_d    = '0;
               asm_clear = 1'b1;
`ifdef XPROG_LDR_CHECKSUM_EN
               csum_d    = '0;
`endif
            end
         end
         LDR_LEN_HI: begin
            if (accept) begin
               len_d   = {rx_data, 8'h00};
               state_d = LDR_LEN_LO;
            end
         end
         LDR_LEN_LO: begin
            if (accept) begin
               len_d = {len_q[15:8], rx_data};
               n_rx  = {1'b0, len_q[15:8], rx_data};
               if (n_rx > MAX_N)
                  state_d = LDR_ERR;
               else if (n_rx == '0)
                  state_d = FINAL_ST;
               else
                  state_d = LDR_WORD;
            end
         end
         LDR_WORD: begin
            if (accept) begin
               asm_shift = 1'b1;
`ifdef XPROG_LDR_CHECKSUM_EN
               csum_d    = csum_q ^ rx_data;
`endif
               if (asm_full)
                  state_d = LDR_WRITE;
            end
         end
         // The outputs show the live index/word here; the hold registers keep them afterwards.
         LDR_WRITE: begin
            idx_d  = idx_q + 16'd1;
            addr_d = idx_q[ADDR_W-1:0];
            din_d  = asm_word;
            if (idx_q + 16'd1 == len_q)
               state_d = FINAL_ST;
            else
               state_d = LDR_WORD;
         end
`ifdef XPROG_LDR_CHECKSUM_EN
         LDR_CHK: begin
            if (accept)
               state_d = ((csum_q ^ rx_data) == 8'h00) ? LDR_DONE : LDR_ERR;
         end
`endif
         default: state_d = LDR_ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LDR_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
`ifdef XPROG_LDR_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
`ifdef XPROG_LDR_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign data_sel  = (state_q == LDR_WRITE);
   assign data_we   = (state_q == LDR_WRITE);
   assign data_addr = (state_q == LDR_WRITE) ? idx_q[ADDR_W-1:0] : addr_q;
   assign data_in   = (state_q == LDR_WRITE) ? asm_word : din_q;
   assign busy      = !(state_q inside {LDR_IDLE, LDR_DONE, LDR_ERR});
   assign done      = (state_q == LDR_DONE);
   assign err       = (state_q == LDR_ERR);
   // The CPU is only released by a successful load; reset and errors keep it held.
   assign cpu_rst   = (state_q != LDR_DONE);

endmodule

// File: tb/tb_xprog_loader.sv
// Directed, table-driven bench for xprog_loader (32-bit words, 9-bit address).
// Checksum vectors change their expectations when XPROG_LDR_CHECKSUM_EN is defined.
module tb_xprog_loader;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int LIMIT  = 6000;

   typedef struct {
      logic [15:0] n;
      int          nsend;
      logic [31:0] w0, w1, w2, w3;
      bit          toggle;
      bit          bad_csum;
      int          start_at;
      int          abort_at;
      bit          exp_done;
      bit          exp_err;
      int          exp_nwr;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              data_sel;
   logic              data_we;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_in;
   logic              busy, done, err, cpu_rst;

   int n_tests = 0;
   int n_fail  = 0;
   int bytes_sent, bytes_total;
   int proto_err;
   logic [ADDR_W-1:0] wr_addr[$];
   logic [DATA_W-1:0] wr_data[$];
   logic              prev_we;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] last_data;
   vec_t              vecs[9];

   xprog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .data_sel (data_sel),
      .data_we  (data_we),
      .data_addr(data_addr),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .cpu_rst  (cpu_rst)
   );

   always #5 clk = ~clk;

   // Records every RAM write and flags one-cycle-pulse or hold violations.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_we = 1'b0;
      end else begin
         if (data_we) begin
            wr_addr.push_back(data_addr);
            wr_data.push_back(data_in);
            if (prev_we || !data_sel || rx_ready) proto_err++;
         end else begin
            if (data_sel) proto_err++;
            if (prev_we && (data_addr != last_addr || data_in != last_data)) proto_err++;
         end
         last_addr = data_addr;
         last_data = data_in;
         prev_we   = data_we;
      end
   end

   function automatic vec_t mk(input logic [15:0] n, input int nsend,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input bit tog, input bit bad, input int start_at,
                               input bit e_done, input bit e_err, input int e_wr);
      vec_t v;
      v.n = n; v.nsend = nsend; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
      v.toggle = tog; v.bad_csum = bad; v.start_at = start_at; v.abort_at = -1;
      v.exp_done = e_done; v.exp_err = e_err; v.exp_nwr = e_wr;
      return v;
   endfunction

   function automatic logic [31:0] wordVal(input vec_t v, input int i);
      case (i)
         0: return v.w0;
         1: return v.w1;
         2: return v.w2;
         3: return v.w3;
         default: return {i[15:0], ~i[15:0]};
      endcase
   endfunction

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   task automatic checkReset();
      cmp("rst rx_ready", rx_ready, 0);
      cmp("rst data_sel", data_sel, 0);
      cmp("rst data_we", data_we, 0);
      cmp("rst data_addr", data_addr, 0);
      cmp("rst data_in", data_in, 0);
      cmp("rst busy", busy, 0);
      cmp("rst done", done, 0);
      cmp("rst err", err, 0);
      cmp("rst cpu_rst", cpu_rst, 1);
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [7:0]  bytes[$];
      logic [7:0]  x;
      logic [31:0] w;
      bit          acc;
      bit          pulsed;
      int          cyc;
      bytes.delete();
      bytes.push_back(v.n[15:8]);
      bytes.push_back(v.n[7:0]);
      x = 8'h00;
      for (int i = 0; i < v.nsend; i++) begin
         w = wordVal(v, i);
         for (int b = 3; b >= 0; b--) begin
            bytes.push_back(w[b*8 +: 8]);
            x = x ^ w[b*8 +: 8];
         end
      end
`ifdef XPROG_LDR_CHECKSUM_EN
      if (v.n <= 16'h0200) bytes.push_back(x ^ {7'd0, v.bad_csum});
`endif
      bytes_total = bytes.size();
      @(negedge clk);
      wr_addr.delete();
      wr_data.delete();
      proto_err = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      cmp("busy after start", busy, 1);
      cmp("done cleared by start", done, 0);
      bytes_sent = 0;
      cyc = 0;
      pulsed = 1'b0;
      while (bytes_sent < bytes_total && bytes_sent != v.abort_at && cyc < LIMIT) begin
         rx_valid = v.toggle ? (cyc % 2 == 1) : 1'b1;
         rx_data  = bytes[bytes_sent];
         start    = (bytes_sent == v.start_at) && !pulsed;
         if (start) pulsed = 1'b1;
         #1 acc = rx_valid && rx_ready;
         @(posedge clk);
         if (acc) bytes_sent++;
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (!busy) break;
      end
      rx_valid = 1'b0;
      if (bytes_sent == v.abort_at) return;
      while (busy && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input int id);
      int nw;
      $display("[TB] vector %0d: n=%0h writes=%0d", id, v.n, wr_addr.size());
      cmp("bytes accepted", bytes_sent, bytes_total);
      cmp("busy at end", busy, 0);
      cmp("done", done, v.exp_done);
      cmp("err", err, v.exp_err);
      cmp("cpu_rst", cpu_rst, !v.exp_done);
      cmp("write count", wr_addr.size(), v.exp_nwr);
      cmp("write protocol", proto_err, 0);
      nw = (wr_addr.size() < v.exp_nwr) ? wr_addr.size() : v.exp_nwr;
      for (int i = 0; i < nw; i++) begin
         cmp("write addr", wr_addr[i], i);
         cmp("write data", wr_data[i], wordVal(v, i));
      end
   endtask

   initial begin
      vec_t va;
      rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      proto_err = 0; prev_we = 1'b0;

      vecs[0] = mk(16'h0002, 2, 32'h11223344, 32'hA5A5A5A5, 0, 0, 0, 0, -1, 1, 0, 2);
      vecs[1] = mk(16'h0002, 2, 32'h11223344, 32'hA5A5A5A5, 0, 0, 1, 0, -1, 1, 0, 2);
      vecs[2] = mk(16'h0201, 0, 0, 0, 0, 0, 0, 0, -1, 0, 1, 0);
      vecs[3] = mk(16'h0000, 0, 0, 0, 0, 0, 0, 0, -1, 1, 0, 0);
      vecs[4] = mk(16'h0003, 3, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, -1, 1, 0, 3);
      vecs[5] = mk(16'h0200, 512, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 0, 0, -1, 1, 0, 512);
      vecs[6] = mk(16'h0002, 2, 32'hCAFEF00D, 32'h0BADBEEF, 0, 0, 0, 0, 1, 1, 0, 2);
      vecs[7] = mk(16'h0001, 1, 32'h01020304, 0, 0, 0, 0, 0, -1, 1, 0, 1);
`ifdef XPROG_LDR_CHECKSUM_EN
      vecs[8] = mk(16'h0001, 1, 32'h01020304, 0, 0, 0, 0, 1, -1, 0, 1, 1);
`else
      vecs[8] = mk(16'h0001, 1, 32'h01020304, 0, 0, 0, 0, 1, -1, 1, 0, 1);
`endif

      repeat (3) @(negedge clk);
      #1 checkReset();
      rst_n = 1'b1;
      @(negedge clk);
      #1 checkReset();

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
      end

      // Abort a 2-word load after 5 bytes, then reload from scratch.
      va = vecs[0];
      va.abort_at = 5;
      applyStimulus(va);
      cmp("busy before abort", busy, 1);
      rst_n = 1'b0;
      #1 checkReset();
      cmp("no partial write", wr_addr.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(vecs[0]);
      checkOutput(vecs[0], 100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
